// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner: host-written digit registers, hex decode,
// leading-zero blanking, guard interval between digits and 16-step brightness PWM.
module seg7_scan_ctrl #(
    parameter int DIGITS         = 4,
    parameter int DIV            = 50000,
    parameter int GUARD          = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Wr_en,
    input  logic [2:0]        Wr_addr,
    input  logic [3:0]        Wr_data,
    input  logic              Wr_dp,
    input  logic              Lz_en,
    input  logic [3:0]        Bright,
    output logic [7:0]        Seg,
    output logic [DIGITS-1:0] Sl,
    output logic              Frame_start
);

    localparam int PW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);

    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] dp;
    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic [3:0]        pwm;
    logic              tick;
    logic [DIGITS-1:0] blank;
    logic [7:0]        seg_nxt;
    logic [DIGITS-1:0] sel_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    assign tick = (presc == PW'(DIV - 1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DIGITS; i++) nib[i] <= '0;
            dp <= '0;
        end else if (Wr_en && (int'(Wr_addr) < DIGITS)) begin
            nib[Wr_addr[IW-1:0]] <= Wr_data;
            dp[Wr_addr[IW-1:0]]  <= Wr_dp;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            presc <= '0;
            idx   <= '0;
            pwm   <= '0;
        end else begin
            pwm   <= pwm + 4'd1;
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end
    end

    // Blanking runs from the top digit down and stops at the first nonzero nibble.
    always_comb begin
        logic run;
        blank = '0;
        run   = Lz_en;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run      = run && (nib[i] == 4'h0);
            blank[i] = run;
        end
    end

    always_comb begin
        seg_nxt = {dp[idx], blank[idx] ? 7'h00 : hex7(nib[idx])};
        sel_nxt = '0;
        if ((presc >= PW'(GUARD)) && (pwm <= Bright)) sel_nxt = DIGITS'(1) << idx;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Seg         <= {8{SEG_ACTIVE_LOW}};
            Sl          <= {DIGITS{SEL_ACTIVE_LOW}};
            Frame_start <= 1'b0;
        end else begin
            Seg         <= seg_nxt ^ {8{SEG_ACTIVE_LOW}};
            Sl          <= sel_nxt ^ {DIGITS{SEL_ACTIVE_LOW}};
            Frame_start <= (presc == '0) && (idx == '0);
        end
    end

endmodule
